// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: external bus bridge states and chip-select decode helper.
package CPU_PKG;

  typedef enum logic [1:0] {
    EBS_IDLE,
    EBS_SETUP,
    EBS_REQ,
    EBS_DONE
  } ExtBrgState_t;

  // Lowest-numbered active chip-select wins when several areas match.
  function automatic logic [1:0] lowest_area(input logic [3:0] hit);
    if (hit[0]) return 2'd0;
    if (hit[1]) return 2'd1;
    if (hit[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/sh_ext_bus_tmo.sv
// REQ-phase timeout counter for sh_ext_mem_bridge; present only with SH_EXT_BUS_TIMEOUT_EN.
`ifdef SH_EXT_BUS_TIMEOUT_EN
module sh_ext_bus_tmo #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic EN,
  input  logic CLR,
  input  logic CE,
  output logic HIT
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // HIT marks the CE tick on which the count reaches TIMEOUT.
  assign HIT = EN && CE && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (CLR) begin
      cnt <= '0;
    end else if (EN && CE) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/sh_ext_mem_bridge.sv
// SH7604 external bus to request/acknowledge memory bridge.
// Optional REQ timeout enabled by defining SH_EXT_BUS_TIMEOUT_EN.
module sh_ext_mem_bridge
  import CPU_PKG::*;
#(
  parameter logic [3:0]  CS_EN   = 4'b1111,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic [26:0] A,
  input  logic [31:0] DO,
  output logic [31:0] DI,
  input  logic        BS_N,
  input  logic [3:0]  CS_N,
  input  logic        RD_WR_N,
  input  logic [3:0]  WE_N,
  output logic        WAIT_N,
  output logic [26:0] MEM_A,
  output logic [1:0]  MEM_AREA,
  output logic [31:0] MEM_DO,
  output logic [3:0]  MEM_BE,
  output logic        MEM_WE,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_DI,
  output logic        TO_ERR
);

  ExtBrgState_t state, state_nxt;
  logic [3:0]   cs_hit;
  logic         sel;
  logic         tmo_hit;
  logic         to_err_q;

  assign cs_hit  = ~CS_N & CS_EN;
  assign sel     = ~BS_N & (|cs_hit);
  assign MEM_REQ = (state == EBS_REQ);

`ifdef SH_EXT_BUS_TIMEOUT_EN
  sh_ext_bus_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (state == EBS_REQ),
    .CLR   ((state == EBS_SETUP) && CE_R),
    .CE    (CE_R),
    .HIT   (tmo_hit)
  );
  assign TO_ERR = to_err_q;
`else
  assign tmo_hit = 1'b0;
  // TIMEOUT is only meaningful with the counter; referenced here so it stays bound.
  assign TO_ERR  = to_err_q && (TIMEOUT == 0);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= EBS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    WAIT_N    = 1'b1;
    unique case (state)
      EBS_IDLE: begin
        // Reset gating keeps WAIT_N released while the CPU still drives a select.
        WAIT_N = ~(sel & RST_N);
        if (CE_R && sel) state_nxt = EBS_SETUP;
      end
      EBS_SETUP: begin
        WAIT_N = 1'b0;
        if (CE_R) state_nxt = EBS_REQ;
      end
      EBS_REQ: begin
        WAIT_N = 1'b0;
        if (MEM_ACK || tmo_hit) state_nxt = EBS_DONE;
      end
      EBS_DONE: begin
        if (CE_R && CS_N[MEM_AREA]) state_nxt = EBS_IDLE;
      end
      default: state_nxt = EBS_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DI       <= '0;
      MEM_A    <= '0;
      MEM_AREA <= '0;
      MEM_DO   <= '0;
      MEM_BE   <= '0;
      MEM_WE   <= 1'b0;
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= 1'b0;
      unique case (state)
        EBS_IDLE: begin
          if (CE_R && sel) begin
            MEM_A    <= A;
            MEM_AREA <= lowest_area(cs_hit);
            MEM_WE   <= ~RD_WR_N;
          end
        end
        EBS_SETUP: begin
          if (CE_R) begin
            MEM_DO <= DO;
            MEM_BE <= MEM_WE ? ~WE_N : '1;
          end
        end
        EBS_REQ: begin
          // An ACK coinciding with the timeout tick takes priority.
          if (MEM_ACK) begin
            if (!MEM_WE) DI <= MEM_DI;
          end else if (tmo_hit) begin
            if (!MEM_WE) DI <= '1;
            to_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sh_ext_mem_bridge.sv
// Scoreboard bench for sh_ext_mem_bridge; timeout cases run when SH_EXT_BUS_TIMEOUT_EN is defined.
module tb_sh_ext_mem_bridge;

  localparam logic [3:0] CS_EN_TB = 4'b1101;

  logic        CLK, RST_N, CE_R, BS_N, RD_WR_N, WAIT_N;
  logic        MEM_WE, MEM_REQ, MEM_ACK, TO_ERR;
  logic [26:0] A, MEM_A;
  logic [31:0] DO, DI, MEM_DO, MEM_DI;
  logic [3:0]  CS_N, WE_N, MEM_BE;
  logic [1:0]  MEM_AREA;

  sh_ext_mem_bridge #(.CS_EN(CS_EN_TB), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .A(A), .DO(DO), .DI(DI),
    .BS_N(BS_N), .CS_N(CS_N), .RD_WR_N(RD_WR_N), .WE_N(WE_N), .WAIT_N(WAIT_N),
    .MEM_A(MEM_A), .MEM_AREA(MEM_AREA), .MEM_DO(MEM_DO), .MEM_BE(MEM_BE),
    .MEM_WE(MEM_WE), .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK), .MEM_DI(MEM_DI),
    .TO_ERR(TO_ERR)
  );

  typedef struct {
    logic [26:0] a;
    logic [1:0]  area;
    logic        we;
    logic [3:0]  be;
    logic [31:0] dout;
    logic [31:0] di;
    int          len;
    logic        to;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          have_cur;
  int          checks, errors;
  int          req_count, to_count;
  int          ack_delay;
  logic        ack_en;
  logic [31:0] ack_data;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // CE_R is high on every other rising edge; it settles well before the falling edge.
  initial begin
    CE_R = 1'b0;
    forever begin
      @(posedge CLK);
      #2 CE_R = ~CE_R;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory model: acknowledges each request after ack_delay falling edges.
  initial begin
    MEM_ACK = 1'b0;
    MEM_DI  = 32'hDEADBEEF;
    forever begin
      @(negedge CLK);
      if (MEM_REQ === 1'b1 && RST_N === 1'b1) begin
        if (ack_en) begin
          repeat (ack_delay) @(negedge CLK);
          MEM_ACK = 1'b1;
          MEM_DI  = ack_data;
          @(negedge CLK);
          MEM_ACK = 1'b0;
          MEM_DI  = 32'hDEADBEEF;
        end else begin
          while (MEM_REQ === 1'b1) @(negedge CLK);
        end
      end
    end
  end

  // Monitor: pairs each MEM_REQ burst with the next expectation.
  initial begin
    logic prev;
    int   len;
    prev = 1'b0;
    len  = 0;
    forever begin
      @(negedge CLK);
      if (TO_ERR === 1'b1) to_count++;
      if (MEM_REQ === 1'b1 && !prev) begin
        req_count++;
        len = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 1, 0);
          have_cur = 1'b0;
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (MEM_REQ === 1'b1) begin
        len++;
        if (have_cur) begin
          chk("mem_a", MEM_A, cur.a);
          chk("mem_area", MEM_AREA, cur.area);
          chk("mem_we", MEM_WE, cur.we);
          chk("mem_be", MEM_BE, cur.be);
          chk("mem_do", MEM_DO, cur.dout);
        end
      end
      if (MEM_REQ !== 1'b1 && prev && have_cur && RST_N === 1'b1) begin
        chk("req_len", len, cur.len);
        chk("wait_n_release", WAIT_N, 1);
        chk("di", DI, cur.di);
        chk("to_err", TO_ERR, cur.to);
      end
      prev = (MEM_REQ === 1'b1);
    end
  end

  task automatic wait_tick();
    do @(negedge CLK); while (CE_R !== 1'b1);
  endtask

  task automatic cpu_access(input logic [26:0] a, input logic [3:0] cs_n, input logic rd,
                            input logic [3:0] we_n, input logic [31:0] dout,
                            input int hold, input bit bs_pulse);
    int n;
    wait_tick();
    A = a; CS_N = cs_n; RD_WR_N = rd; WE_N = we_n; DO = dout; BS_N = 1'b0;
    #1 chk("idle_sel_wait_n", WAIT_N, 0);
    @(negedge CLK);
    BS_N = 1'b1;
    for (n = 0; n < 200; n++) begin
      wait_tick();
      if (WAIT_N === 1'b1) break;
    end
    if (n == 200) chk("wait_release_budget", 0, 1);
    for (int i = 0; i < hold; i++) begin
      wait_tick();
      BS_N = (bs_pulse && i == 4) ? 1'b0 : 1'b1;
      #1 chk("done_hold_wait_n", WAIT_N, 1);
    end
    wait_tick();
    CS_N = 4'hF; BS_N = 1'b1;
    wait_tick();
    wait_tick();
  endtask

  initial begin
    int          rc0, to0, to_exp;
    logic [31:0] last_di;
    checks = 0; errors = 0; req_count = 0; to_count = 0; have_cur = 1'b0;
    RST_N = 1'b0; BS_N = 1'b1; CS_N = 4'hF; A = '0; DO = '0; RD_WR_N = 1'b1; WE_N = 4'hF;
    ack_en = 1'b1; ack_delay = 3; ack_data = '0;
    to_exp = 0;

    repeat (3) @(negedge CLK);
    chk("rst_di", DI, 0);
    chk("rst_wait_n", WAIT_N, 1);
    chk("rst_mem_req", MEM_REQ, 0);
    chk("rst_mem_we", MEM_WE, 0);
    chk("rst_mem_be", MEM_BE, 0);
    chk("rst_mem_a", MEM_A, 0);
    chk("rst_mem_area", MEM_AREA, 0);
    chk("rst_mem_do", MEM_DO, 0);
    chk("rst_to_err", TO_ERR, 0);
    RST_N = 1'b1;

    // Read CS0, ACK three clocks into REQ.
    ack_delay = 3; ack_data = 32'h12345678;
    exp_q.push_back('{27'h0000100, 2'd0, 1'b0, 4'hF, 32'h11111111, 32'h12345678, 4, 1'b0});
    cpu_access(27'h0000100, 4'b1110, 1'b1, 4'hF, 32'h11111111, 0, 1'b0);
    last_di = 32'h12345678;

    // Write CS2 with two byte lanes; DI must hold the previous read data.
    ack_delay = 1; ack_data = 32'h0;
    rc0 = req_count;
    exp_q.push_back('{27'h0000204, 2'd2, 1'b1, 4'b0011, 32'hCAFEBABE, last_di, 2, 1'b0});
    cpu_access(27'h0000204, 4'b1011, 1'b0, 4'b1100, 32'hCAFEBABE, 0, 1'b0);
    chk("write_one_req", req_count - rc0, 1);

    // CS1 is not enabled: no wait, no request.
    rc0 = req_count;
    wait_tick();
    A = 27'h0000300; CS_N = 4'b1101; RD_WR_N = 1'b1; BS_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("cs1_wait_n", WAIT_N, 1);
    end
    BS_N = 1'b1; CS_N = 4'hF;
    repeat (4) @(negedge CLK);
    chk("cs1_no_req", req_count - rc0, 0);

    // CS0 and CS3 together; CS0 held long with a stray BS_N while in DONE.
    ack_delay = 0; ack_data = 32'hA5A55A5A;
    rc0 = req_count;
    exp_q.push_back('{27'h7FFFFFF, 2'd0, 1'b0, 4'hF, 32'h0, 32'hA5A55A5A, 1, 1'b0});
    cpu_access(27'h7FFFFFF, 4'b0110, 1'b1, 4'b0000, 32'h0, 10, 1'b1);
    chk("hold_one_req", req_count - rc0, 1);
    last_di = 32'hA5A55A5A;

`ifdef SH_EXT_BUS_TIMEOUT_EN
    // No ACK: 16 CE ticks in REQ abort the read.
    ack_en = 1'b0;
    to0 = to_count;
    exp_q.push_back('{27'h0000040, 2'd3, 1'b0, 4'hF, 32'h0, 32'hFFFFFFFF, 32, 1'b1});
    cpu_access(27'h0000040, 4'b0111, 1'b1, 4'hF, 32'h0, 0, 1'b0);
    chk("tmo_pulses", to_count - to0, 1);
    to_exp = 1;

    // ACK on the 16th tick wins over the timeout.
    ack_en = 1'b1; ack_delay = 31; ack_data = 32'h0BADF00D;
    to0 = to_count;
    exp_q.push_back('{27'h0000044, 2'd0, 1'b0, 4'hF, 32'h0, 32'h0BADF00D, 32, 1'b0});
    cpu_access(27'h0000044, 4'b1110, 1'b1, 4'hF, 32'h0, 0, 1'b0);
    chk("tmo_ack_wins", to_count - to0, 0);
`endif

    // Reset in the middle of a write request.
    ack_en = 1'b0;
    exp_q.push_back('{27'h0000555, 2'd2, 1'b1, 4'b1010, 32'h55AA55AA, 32'h0, 0, 1'b0});
    wait_tick();
    A = 27'h0000555; CS_N = 4'b1011; RD_WR_N = 1'b0; WE_N = 4'b0101; DO = 32'h55AA55AA; BS_N = 1'b0;
    @(negedge CLK);
    BS_N = 1'b1;
    for (int i = 0; i < 20 && MEM_REQ !== 1'b1; i++) @(negedge CLK);
    chk("rst_req_seen", MEM_REQ, 1);
    @(posedge CLK);
    BS_N = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_mem_req", MEM_REQ, 0);
    chk("midrst_wait_n", WAIT_N, 1);
    chk("midrst_mem_a", MEM_A, 0);
    chk("midrst_di", DI, 0);
    CS_N = 4'hF; BS_N = 1'b1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Fresh read after reset.
    ack_en = 1'b1; ack_delay = 0; ack_data = 32'h600DCAFE;
    exp_q.push_back('{27'h0000010, 2'd0, 1'b0, 4'hF, 32'h0, 32'h600DCAFE, 1, 1'b0});
    cpu_access(27'h0000010, 4'b1110, 1'b1, 4'hF, 32'h0, 0, 1'b0);

    repeat (4) @(negedge CLK);
    chk("queue_empty", exp_q.size(), 0);
    chk("to_err_total", to_count, to_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/sh_ext_mem_bridge.md
# sh_ext_mem_bridge

Bridges the SH7604 external bus pins to a generic synchronous request/acknowledge memory port. It sits directly downstream of the CPU's bus state controller pins. It decodes chip-selects CS0–CS3 and holds the CPU with WAIT_N until the memory acknowledges. It returns read data on the CPU's DI bus and forwards write data and byte strobes to memory.

## Interface
- CS_EN, 4'b1111: per-area service mask; bit n set means this bridge services CSn.
- TIMEOUT, 256: number of CE_R ticks in REQ before abort (used only with the timeout macro).
- CLK in 1: system clock.
- RST_N in 1: reset, asynchronous, active-low.
- CE_R in 1: CPU rising clock enable; all pin sampling is gated by it.
- A in 27: CPU address.
- DO in 32: CPU write data.
- DI out 32: read data to CPU.
- BS_N in 1: bus start strobe.
- CS_N in 4: {CS3_N,CS2_N,CS1_N,CS0_N}.
- RD_WR_N in 1: 1 = read, 0 = write.
- WE_N in 4: byte write strobes, active-low; bit 3 = D31..24.
- WAIT_N out 1: wait request to CPU, active-low.
- MEM_A out 27: latched address.
- MEM_AREA out 2: index of the serviced chip-select.
- MEM_DO out 32: write data.
- MEM_BE out 4: byte enables, active-high.
- MEM_WE out 1: 1 = write.
- MEM_REQ out 1: request, level.
- MEM_ACK in 1: acknowledge, one-CLK pulse.
- MEM_DI in 32: read data, valid with MEM_ACK.
- TO_ERR out 1: timeout pulse (macro only; otherwise tied 0).

## Operation
- Reset values: DI=0, WAIT_N=1, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_A=0, MEM_AREA=0, MEM_DO=0, TO_ERR=0, state IDLE.
- SEL means BS_N=0 and some n has CS_N[n]=0 with CS_EN[n]=1. When several areas match, the lowest n wins.
- IDLE: on a CE_R tick with SEL, latch A, area and RD_WR_N, then go to SETUP.
- SETUP: on the next CE_R tick, latch DO. Latch MEM_BE = RD_WR_N ? 4'hF : ~WE_N. Then go to REQ.
- REQ: MEM_REQ=1. MEM_ACK is sampled on every CLK, not gated by CE_R. On MEM_ACK:
  - Read: DI <= MEM_DI.
  - Then go to DONE.
  - MEM_REQ falls on the CLK edge after the ACK.
- DONE: waits for a CE_R tick where the serviced CS_N[area]=1, then goes to IDLE. This keeps one CPU access from issuing two requests.
- WAIT_N is combinational:
  - 0 in SETUP and REQ.
  - 0 in IDLE when SEL is true.
  - 1 otherwise.
- MEM_ACK outside REQ is ignored.
- DI holds its last value until the next read ACK.
- Areas with CS_EN[n]=0 are never decoded; WAIT_N stays 1 for them.
- Asynchronous reset mid-access returns immediately to IDLE with reset values; the pending memory transfer is abandoned.

## Timing
- Minimum read: SEL tick T0, SETUP at T1, REQ from T1 edge. With ACK on the first REQ CLK, WAIT_N releases the CLK after the ACK, and DI is valid at the same time.
- CPU-visible latency = 2 CE_R ticks + memory ACK latency + 1 CLK.
- MEM_A, MEM_AREA, MEM_WE, MEM_BE and MEM_DO are stable for the whole time MEM_REQ=1.
- Back-to-back accesses need CS_N to be high for at least one CE_R tick between them.

## Configuration
- SH_EXT_BUS_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each CE_R tick in REQ.
  - On reaching TIMEOUT without ACK: MEM_REQ drops, a read returns DI=32'hFFFFFFFF, TO_ERR pulses for one CLK, and the state goes to DONE.
  - An ACK arriving in the same CLK as the timeout wins; no TO_ERR is raised.
- SH_EXT_BUS_TIMEOUT_EN undefined: no counter, TO_ERR=0, and REQ waits indefinitely.

## Structure
- Add the state enum ExtBrgState_t {EBS_IDLE, EBS_SETUP, EBS_REQ, EBS_DONE} to CPU_PKG.
- The timeout counter is the natural sub-module: sh_ext_bus_tmo (enable, clear, CE-gated count, terminal flag). Instantiate it only under the macro.

## Test plan
- Read, CS0: A=27'h0000100, MEM_ACK 3 CLK after REQ with MEM_DI=32'h12345678 -> MEM_A=27'h0000100, MEM_BE=4'hF, MEM_WE=0, DI=32'h12345678, WAIT_N=1 the CLK after ACK.
- Write, CS2: DO=32'hCAFEBABE, WE_N=4'b1100 -> MEM_WE=1, MEM_BE=4'b0011, MEM_AREA=2, exactly one MEM_REQ burst.
- CS_EN=4'b0001 with a CS1 access -> WAIT_N stays 1 and MEM_REQ never asserts.
- CS0 and CS3 both low -> MEM_AREA=0. Hold CS0 low 10 ticks after ACK -> still a single request, and it returns to IDLE only after CS0_N rises.
- Macro on, TIMEOUT=16, no ACK -> MEM_REQ drops after 16 CE_R ticks, TO_ERR pulses once, DI=32'hFFFFFFFF. Repeat with ACK on tick 16 -> ACK data is returned and TO_ERR=0.
- RST_N low during REQ -> MEM_REQ=0 and WAIT_N=1 immediately. A fresh access after reset completes normally.
